// File: rtl/xadc_wb_poller.sv
// xadc_wb_poller
//   Wishbone classic-cycle master that repeatedly sweeps five XADC status
//   registers (temperature, VCCINT, VCCAUX, VCCBRAM, VAUX14) through the XADC
//   Wishbone slave. It caches the 12-bit result of each channel so fan-control
//   and health logic can read them without touching the bus. Bus errors and
//   transaction timeouts raise sticky flags.
//
// Ports
//   clk, rst_n        bus clock, asynchronous active-low reset
//   enable            permits new sweeps (a started sweep always completes)
//   clear_err         clears bus_err_o / timeout_o (a same-cycle set wins)
//   wb_*              Wishbone master port (read-only: we = 0, dat_o = 0)
//   temp_o .. vaux14_o  latest conversion results (wb_dat_i[15:4])
//   valid_o           per-channel "read at least once" flags, temp = bit 0
//   sweep_done_o      one-cycle pulse after the fifth transaction of a sweep
//   bus_err_o         sticky: an err response was received
//   timeout_o         sticky: a transaction received neither ack nor err
module xadc_wb_poller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_DIV  = 1_000_000,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [11:0] temp_o,
  output logic [11:0] vccint_o,
  output logic [11:0] vccaux_o,
  output logic [11:0] vccbram_o,
  output logic [11:0] vaux14_o,
  output logic [4:0]  valid_o,
  output logic        sweep_done_o,
  output logic        bus_err_o,
  output logic        timeout_o
);

  localparam int unsigned NCH   = 5;
  localparam int unsigned DIV_W = $clog2(POLL_DIV + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(POLL_DIV - 1);
  localparam logic [TMO_W-1:0] WAIT_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_NEXT} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         idx_reg, idx_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [TMO_W-1:0]   wait_reg, wait_next;
  logic [31:0]        adr_reg, adr_next;
  logic               done_reg, done_next;
  logic               bus_err_reg, bus_err_next;
  logic               timeout_reg, timeout_next;
  logic [11:0]        value_reg [NCH];
  logic [NCH-1:0]     valid_reg;
  logic               ack_hit, err_hit, tmo_hit;
  logic [NCH-1:0]     cap;

  // Only wb_dat_i[15:4] carries the conversion result.
  logic unused_dat;
  assign unused_dat = ^{wb_dat_i[31:16], wb_dat_i[3:0]};

  // DRP address of each swept channel; registers sit on 32-bit boundaries.
  function automatic logic [31:0] chan_addr(input logic [2:0] i);
    logic [4:0] drp;
    case (i)
      3'd0:    drp = 5'h00;
      3'd1:    drp = 5'h01;
      3'd2:    drp = 5'h02;
      3'd3:    drp = 5'h06;
      default: drp = 5'h1E;
    endcase
    return BASE_ADDR + {25'd0, drp, 2'b00};
  endfunction

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    div_next   = div_reg;
    wait_next  = wait_reg;
    adr_next   = adr_reg;
    done_next  = 1'b0;
    ack_hit    = 1'b0;
    err_hit    = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable && (div_reg == '0)) begin
          adr_next   = chan_addr(idx_reg);
          wait_next  = '0;
          state_next = S_REQ;
        end else if (div_reg != '0) begin
          // The poll interval keeps running while enable is low.
          div_next = div_reg - 1'b1;
        end
      end
      S_REQ: begin
        wait_next = wait_reg + 1'b1;
        // ack beats err, and any response beats the timeout.
        if (wb_ack_i) begin
          ack_hit    = 1'b1;
          state_next = S_NEXT;
        end else if (wb_err_i) begin
          err_hit    = 1'b1;
          state_next = S_NEXT;
        end else if (wait_reg == WAIT_LAST) begin
          tmo_hit    = 1'b1;
          state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_reg == 3'd4) begin
          idx_next   = 3'd0;
          done_next  = 1'b1;
          div_next   = DIV_RELOAD;
          state_next = S_IDLE;
        end else begin
          // Mid-sweep: continue regardless of enable.
          idx_next   = idx_reg + 3'd1;
          adr_next   = chan_addr(idx_reg + 3'd1);
          wait_next  = '0;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as clear_err survives.
  assign bus_err_next = (bus_err_reg & ~clear_err) | err_hit;
  assign timeout_next = (timeout_reg & ~clear_err) | tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cap
      assign cap[gi] = ack_hit && (idx_reg == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      div_reg     <= '0;
      wait_reg    <= '0;
      adr_reg     <= '0;
      done_reg    <= 1'b0;
      bus_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
      valid_reg   <= '0;
      for (int i = 0; i < NCH; i++) value_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      div_reg     <= div_next;
      wait_reg    <= wait_next;
      adr_reg     <= adr_next;
      done_reg    <= done_next;
      bus_err_reg <= bus_err_next;
      timeout_reg <= timeout_next;
      for (int i = 0; i < NCH; i++) begin
        if (cap[i]) begin
          value_reg[i] <= wb_dat_i[15:4];
          valid_reg[i] <= 1'b1;
        end
      end
    end
  end

  // cyc/stb decode straight from the state register, so reset drops them
  // asynchronously and they are glitch-free.
  assign wb_cyc_o     = (state_reg == S_REQ);
  assign wb_stb_o     = (state_reg == S_REQ);
  assign wb_we_o      = 1'b0;
  assign wb_dat_o     = 32'h0;
  assign wb_adr_o     = adr_reg;
  assign temp_o       = value_reg[0];
  assign vccint_o     = value_reg[1];
  assign vccaux_o     = value_reg[2];
  assign vccbram_o    = value_reg[3];
  assign vaux14_o     = value_reg[4];
  assign valid_o      = valid_reg;
  assign sweep_done_o = done_reg;
  assign bus_err_o    = bus_err_reg;
  assign timeout_o    = timeout_reg;

endmodule
